alu_seq_mult: RTL and testbench
===============================

Name: alu_seq_mult

Overview:
- Sequential radix-2 shift-and-add multiplier that sits directly upstream of the ALU's 16-to-1 result mux.
- Its low-half product drives the mux's MUL input slot (select 4'hA); its high-half product drives the MULH slot (select 4'hB).
- Takes WIDTH-bit operands on a start pulse, iterates one multiplier bit per cycle, then holds a registered result with a done strobe.
- The ALU control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle strobe when Z/ZH become valid
- Z  output  WIDTH  low half of the 2*WIDTH product
- ZH  output  WIDTH  high half of the product

Behaviour:
- Reset: clk and rstb only; reset is synchronous and active-low. When rstb=0 at a clk edge: state=IDLE, busy=0, done=0, Z=0, ZH=0, counter=0, internal accumulators cleared.
- Reset mid-RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch operands, go to RUN. Otherwise stay.
  - RUN: busy=1. Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator (carry kept). Shift the accumulator/multiplier right by 1, counter++. When counter reaches WIDTH-1 on this cycle, go to DONE.
  - DONE: done=1 for exactly this cycle; Z/ZH are updated on entry. start=1 here -> new operation, go to RUN (back-to-back allowed). Otherwise go to IDLE.
- Latency: start accepted at edge N -> busy from N+1 through N+WIDTH -> done high in cycle N+WIDTH+1. For WIDTH=32 that is 33 cycles start-to-done.
- start in RUN is ignored; operands are not re-sampled.
- Signed mode:
  - Latch |A| and |B| and sign = A[MSB]^B[MSB]. Magnitude of the most-negative value is 2^(WIDTH-1), held in WIDTH bits unsigned.
  - On RUN->DONE, if sign=1, negate the full 2*WIDTH product (two's complement) before loading Z/ZH.
- Unsigned mode: product loaded as-is.
- Z/ZH hold their value from DONE until the next DONE or reset; they are stable while busy.
- Zero operand: still full latency (unless the optional feature is enabled); result 0 with no sign artefact (negating 0 yields 0).
- No overflow flag; the full product always fits in 2*WIDTH.

Optional Feature:
- Macro: ALU_MULT_EARLY_TERM_EN.
- Defined: in RUN, if the remaining unshifted multiplier bits are all zero, finish alignment with a single combined shift (shift by WIDTH-1-counter) and go to DONE next cycle. Minimum latency 2 cycles (start -> one RUN cycle -> done). busy deasserts accordingly. The result is identical to the full iteration.
- Undefined: fixed latency WIDTH+1 cycles in all cases.

Decomposition:
- Shared package alu_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - mux select constants ALU_SEL_MUL=4'hA and ALU_SEL_MULH=4'hB, shared with the 16-to-1 mux consumer.
- One natural sub-module: twos_negate #(WIDTH) (combinational conditional negate). Instantiated three times: |A|, |B|, and the 2*WIDTH product (with WIDTH overridden to 2*WIDTH).
- FSM and counter stay in the top.

Test Plan:
- Unsigned, WIDTH=32: A=32'd7, B=32'd6, signed_op=0 -> done exactly 33 cycles after start; Z=32'd42, ZH=0; busy high for 32 cycles.
- Signed: A=-3 (32'hFFFFFFFD), B=5, signed_op=1 -> Z=32'hFFFFFFF1, ZH=32'hFFFFFFFF. Same operands with signed_op=0 -> Z=32'hFFFFFFF1, ZH=32'h00000004.
- Extremes:
  - A=B=32'h80000000, signed_op=1 -> Z=0, ZH=32'h40000000.
  - A=B=32'hFFFFFFFF, unsigned -> Z=32'h00000001, ZH=32'hFFFFFFFE.
- Back-to-back and ignored start: start held high in DONE with A=2, B=3 -> RUN re-entered the next cycle, second done 33 cycles later with Z=6. A start pulse mid-RUN with other operands changes nothing.
- Reset mid-operation: rstb=0 at RUN cycle 10 -> next cycle busy=0, done=0, Z=ZH=0; no done appears later. A subsequent start works normally.
- With ALU_MULT_EARLY_TERM_EN: A=9, B=1 -> done 2 cycles after start, Z=9. Without the macro the same stimulus -> done at 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and result-mux select codes.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Select codes of the 16-to-1 result mux slots fed by the multiplier
  localparam logic [3:0] ALU_SEL_MUL  = 4'hA;
  localparam logic [3:0] ALU_SEL_MULH = 4'hB;

endpackage

// File: rtl/alu_seq_mult_twos_negate.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for restoring the sign of the final product.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1'b1)) : a;

endmodule

// File: rtl/alu_seq_mult.sv
// Sequential radix-2 shift-and-add multiplier feeding the ALU MUL/MULH mux slots.
// Optional macro ALU_MULT_EARLY_TERM_EN: finish early once no multiplier bits remain.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one multiplier bit per cycle, busy high
// DONE   | one-cycle done strobe, Z/ZH freshly loaded; start here chains a new op
module alu_seq_mult
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] ZH
);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic                 sign_q;
  logic [WIDTH-1:0]     z_q, zh_q;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH-1:0]   acc_step, acc_final, prod;
  logic                 last, accept;

  twos_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg (signed_op & A[WIDTH-1]),
    .a   (A),
    .y   (a_mag)
  );

  twos_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg (signed_op & B[WIDTH-1]),
    .a   (B),
    .y   (b_mag)
  );

  twos_negate #(.WIDTH(2*WIDTH)) u_neg_p (
    .neg (sign_q),
    .a   (acc_final),
    .y   (prod)
  );

  // Upper half accumulates the multiplicand; lower half holds the unshifted multiplier bits
  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) upper_sum = upper_sum + {1'b0, mcand};
    acc_step = {upper_sum, acc[WIDTH-1:1]};
  end

`ifdef ALU_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] shamt;

  // After this step cnt+1 shifts are done; the remaining multiplier bits sit below them.
  // At cnt == WIDTH-1 the mask is empty, so the normal end falls out of the same test.
  always_comb begin
    rem_mask  = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
    shamt     = CNT_W'(WIDTH-1) - cnt;
    last      = ((acc_step[WIDTH-1:0] & rem_mask) == '0);
    acc_final = acc_step >> shamt;
  end
`else
  assign last      = (cnt == CNT_W'(WIDTH-1));
  assign acc_final = acc_step;
`endif

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      z_q    <= '0;
      zh_q   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= a_mag;
      acc    <= {{WIDTH{1'b0}}, b_mag};
      sign_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state == S_RUN) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        z_q  <= prod[WIDTH-1:0];
        zh_q <= prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign Z    = z_q;
  assign ZH   = zh_q;

endmodule

// File: tb/tb_alu_seq_mult.sv
// Randomized self-checking bench for alu_seq_mult against an arithmetic product model.
module tb_alu_seq_mult;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done;
  logic [W-1:0] Z, ZH;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_z  = '0;
  logic [W-1:0] exp_zh = '0;

  always #5 clk = ~clk;

  alu_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .signed_op (signed_op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Z         (Z),
    .ZH        (ZH)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Start-to-done cycles: full iteration, or with early termination one RUN
  // cycle per multiplier magnitude bit up to its highest set bit (at least one).
  function automatic int ref_lat(input logic [W-1:0] b, input logic s);
`ifdef ALU_MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int runs;
    mag  = (s && b[W-1]) ? (~b + 1) : b;
    runs = 1;
    for (int i = 0; i < W; i++) if (mag[i]) runs = i + 1;
    return runs + 1;
`else
    return W + 1;
`endif
  endfunction

  // chain=1: caller is in the DONE cycle, so start is sampled there (back-to-back).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit chain, input bit poke);
    logic [2*W-1:0] p;
    int lat, nbusy, exp_lat;
    bit stable;
    p       = ref_prod(a, b, s);
    exp_lat = ref_lat(b, s);
    if (!chain) begin
      @(posedge clk);
      @(negedge clk);
    end
    A = a; B = b; signed_op = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; signed_op = 1'($urandom_range(0, 1));
    lat = 1; nbusy = 0; stable = 1;
    while (!done && lat < W + 4) begin
      if (busy) nbusy++;
      if (Z !== exp_z || ZH !== exp_zh) stable = 0;
      start = poke && (lat == 5);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("latency", lat, exp_lat);
    chk("busy_cycles", nbusy, exp_lat - 1);
    chk("z_stable_while_busy", stable, 1'b1);
    exp_z  = p[W-1:0];
    exp_zh = p[2*W-1:W];
    chk("z", Z, exp_z);
    chk("zh", ZH, exp_zh);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;

    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z", Z, '0);
    chk("rst_zh", ZH, '0);
    @(negedge clk);
    rstb = 1'b1;

    do_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 1'b0);
    do_op(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    do_op(32'd2, 32'd3, 1'b0, 1'b1, 1'b0);
    do_op(32'h12345678, 32'h9ABCDEF1, 1'b0, 1'b0, 1'b1);
    do_op(32'd0, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);
    do_op(32'd9, 32'd1, 1'b0, 1'b0, 1'b0);

    // Abort in the middle of RUN
    @(posedge clk);
    @(negedge clk);
    A = 32'd11; B = 32'd13; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_z", Z, '0);
    chk("abort_zh", ZH, '0);
    @(negedge clk);
    rstb = 1'b1;
    ndone = 0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    exp_z = '0; exp_zh = '0;
    do_op(32'd100, 32'd200, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = 32'h80000000;
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'h80000000;
        2:       rb = 32'(1) << $urandom_range(0, W - 1);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
